// File: rtl/glip_loopback_pkg.sv
// Shared definitions for the GLIP loopback/generate-check tester.
package glip_loopback_pkg;

    localparam logic MODE_LOOPBACK = 1'b0;
    localparam logic MODE_GENCHK   = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/glip_sync_fifo.sv
// First-word-fall-through FIFO on a register array; clr empties it in one cycle.
module glip_sync_fifo
    import glip_loopback_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    empty,
    output logic                    full,
    output logic [clog2(DEPTH):0]   level
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == LVL_FULL);
    assign level  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LVL_ONE;
                2'b01:   r_count <= r_count - LVL_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: dout is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/glip_loopback_tester.sv
// GLIP logic-side tester: FIFO loopback (mode 0) or counter generate/check (mode 1),
// with wrapping rx/tx word counters and a saturating mismatch counter.
module glip_loopback_tester
    import glip_loopback_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    logic_rst,
    input  logic                    mode,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_WIDTH-1:0]    rx_cnt,
    output logic [CNT_WIDTH-1:0]    tx_cnt,
    output logic [CNT_WIDTH-1:0]    err_cnt,
    output logic [clog2(DEPTH):0]   level
);

    localparam int LW = clog2(DEPTH) + 1;
    localparam logic [WIDTH-1:0]     DATA_ONE = WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 r_mode_q;
    logic                 r_flush_q;
    logic                 r_run;
    logic [WIDTH-1:0]     r_gen_cnt;
    logic [WIDTH-1:0]     r_exp_cnt;
    logic [CNT_WIDTH-1:0] r_rx_cnt;
    logic [CNT_WIDTH-1:0] r_tx_cnt;
    logic [CNT_WIDTH-1:0] r_err_cnt;

    logic             w_flush;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_genchk;
    logic             w_mismatch;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic [WIDTH-1:0] w_fifo_dout;
    logic [LW-1:0]    w_fifo_level;

    assign w_flush    = r_flush_q || logic_rst;
    assign w_genchk   = (r_mode_q == MODE_GENCHK);
    assign w_in_hs    = in_valid && in_ready;
    assign w_out_hs   = out_valid && out_ready;
    assign w_mismatch = w_in_hs && w_genchk && (in_data != r_exp_cnt);

    glip_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_flush),
        .push  (w_in_hs && !w_genchk),
        .pop   (w_out_hs && !w_genchk),
        .din   (in_data),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full),
        .level (w_fifo_level)
    );

    // r_run keeps both handshake outputs low while reset is held and for the first edge after.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        if (r_run && !w_flush) begin
            if (w_genchk) begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                out_data  = r_gen_cnt;
            end else begin
                in_ready  = !w_fifo_full;
                out_valid = !w_fifo_empty;
                if (!w_fifo_empty) out_data = w_fifo_dout;
            end
        end
    end

    assign level   = w_flush ? '0 : w_fifo_level;
    assign rx_cnt  = r_rx_cnt;
    assign tx_cnt  = r_tx_cnt;
    assign err_cnt = r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q  <= MODE_LOOPBACK;
            r_flush_q <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_mode_q  <= mode;
            r_flush_q <= (mode != r_mode_q);
            r_run     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen_cnt <= '0;
            r_exp_cnt <= '0;
        end else if (w_flush) begin
            r_gen_cnt <= '0;
            r_exp_cnt <= '0;
        end else if (w_genchk) begin
            if (w_out_hs) r_gen_cnt <= r_gen_cnt + DATA_ONE;
            // A mismatch resynchronises to the received word so one bad word counts once.
            if (w_in_hs)  r_exp_cnt <= in_data + DATA_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_cnt  <= '0;
            r_tx_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (logic_rst) begin
            r_rx_cnt  <= '0;
            r_tx_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_in_hs)  r_rx_cnt <= r_rx_cnt + CNT_ONE;
            if (w_out_hs) r_tx_cnt <= r_tx_cnt + CNT_ONE;
            if (w_mismatch && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_glip_loopback_tester.sv
// Randomised and directed bench for glip_loopback_tester against a queue-based model.
module tb_glip_loopback_tester;
    import glip_loopback_pkg::*;

    localparam int WIDTH     = 16;
    localparam int DEPTH     = 16;
    localparam int CNT_WIDTH = 8;
    localparam int LW        = clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 logic_rst = 1'b0;
    logic                 mode = 1'b0;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [CNT_WIDTH-1:0] rx_cnt;
    logic [CNT_WIDTH-1:0] tx_cnt;
    logic [CNT_WIDTH-1:0] err_cnt;
    logic [LW-1:0]        level;

    always #5 clk = ~clk;

    glip_loopback_tester #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .logic_rst (logic_rst),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rx_cnt    (rx_cnt),
        .tx_cnt    (tx_cnt),
        .err_cnt   (err_cnt),
        .level     (level)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, counters are plain modular values.
    logic [WIDTH-1:0]     m_q[$];
    bit                   m_run, m_mode, m_flush;
    logic [WIDTH-1:0]     m_gen, m_exp;
    logic [CNT_WIDTH-1:0] m_rx, m_tx, m_err;

    bit                   e_in_ready, e_out_valid;
    logic [WIDTH-1:0]     e_out_data;
    logic [LW-1:0]        e_level;

    logic                 s_in_ready, s_out_valid;
    logic [WIDTH-1:0]     s_out_data;
    logic [LW-1:0]        s_level;
    logic [CNT_WIDTH-1:0] s_rx, s_tx, s_err;

    task automatic model_reset();
        m_q.delete();
        m_run = 0; m_mode = 0; m_flush = 0;
        m_gen = '0; m_exp = '0;
        m_rx = '0; m_tx = '0; m_err = '0;
    endtask

    task automatic model_outputs();
        bit fl;
        fl = m_flush || logic_rst;
        e_in_ready = 0; e_out_valid = 0; e_out_data = '0;
        e_level = fl ? '0 : LW'(m_q.size());
        if (m_run && !fl) begin
            if (m_mode) begin
                e_in_ready = 1; e_out_valid = 1; e_out_data = m_gen;
            end else begin
                e_in_ready  = (m_q.size() != DEPTH);
                e_out_valid = (m_q.size() != 0);
                if (m_q.size() != 0) e_out_data = m_q[0];
            end
        end
    endtask

    task automatic model_step(input bit md, input bit lr, input bit iv,
                              input logic [WIDTH-1:0] id, input bit ordy);
        bit fl, hin, hout;
        fl   = m_flush || lr;
        hin  = iv && e_in_ready;
        hout = e_out_valid && ordy;
        if (fl) begin
            m_q.delete();
            m_gen = '0; m_exp = '0;
            if (lr) begin m_rx = '0; m_tx = '0; m_err = '0; end
        end else if (!m_mode) begin
            if (hout) void'(m_q.pop_front());
            if (hin)  m_q.push_back(id);
        end else begin
            if (hout) m_gen = m_gen + WIDTH'(1);
            if (hin) begin
                if (id != m_exp && m_err != {CNT_WIDTH{1'b1}}) m_err = m_err + CNT_WIDTH'(1);
                m_exp = id + WIDTH'(1);
            end
        end
        if (hin)  m_rx = m_rx + CNT_WIDTH'(1);
        if (hout) m_tx = m_tx + CNT_WIDTH'(1);
        m_flush = (md != m_mode);
        m_mode  = md;
        m_run   = 1;
    endtask

    task automatic cycle(input bit md, input bit lr, input bit iv,
                         input logic [WIDTH-1:0] id, input bit ordy);
        @(negedge clk);
        mode = md; logic_rst = lr; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        s_in_ready = in_ready; s_out_valid = out_valid; s_out_data = out_data;
        s_level = level; s_rx = rx_cnt; s_tx = tx_cnt; s_err = err_cnt;
        model_outputs();
        check("in_ready",  32'(in_ready),  32'(e_in_ready));
        check("out_valid", 32'(out_valid), 32'(e_out_valid));
        check("out_data",  32'(out_data),  32'(e_out_data));
        check("level",     32'(level),     32'(e_level));
        check("rx_cnt",    32'(rx_cnt),    32'(m_rx));
        check("tx_cnt",    32'(tx_cnt),    32'(m_tx));
        check("err_cnt",   32'(err_cnt),   32'(m_err));
        @(posedge clk);
        model_step(md, lr, iv, id, ordy);
    endtask

    // Drops rst_n between clock edges and checks that outputs clear without an edge.
    task automatic do_reset();
        #3;
        rst_n = 0; in_valid = 0; logic_rst = 0; out_ready = 0;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_level",     32'(level),     32'd0);
        check("rst_rx",        32'(rx_cnt),    32'd0);
        check("rst_tx",        32'(tx_cnt),    32'd0);
        check("rst_err",       32'(err_cnt),   32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        model_outputs();
        @(posedge clk);
        model_step(mode, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit md, lr, iv, ordy;
        logic [WIDTH-1:0] id;

        do_reset();
        repeat (2) cycle(0, 0, 0, '0, 0);

        // Fill to DEPTH with the output stalled, then drain in order.
        for (int i = 1; i <= 16; i++) cycle(0, 0, 1, WIDTH'(i), 0);
        cycle(0, 0, 0, '0, 0);
        check("t1_full_level", 32'(s_level), 32'd16);
        check("t1_full_ready", 32'(s_in_ready), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            cycle(0, 0, 0, '0, 1);
            check("t1_order", 32'(s_out_data), 32'(i));
        end
        cycle(0, 0, 0, '0, 0);
        check("t1_tx", 32'(s_tx), 32'd16);
        check("t1_rx", 32'(s_rx), 32'd16);

        // Full FIFO with both sides active: first cycle pops only, then level holds at 15.
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, WIDTH'(16'h100 + i), 0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 1, WIDTH'(16'h200 + k), 1);
            if (k == 0) check("t2_ready_full", 32'(s_in_ready), 32'd0);
            else        check("t2_level", 32'(s_level), 32'd15);
        end
        repeat (17) cycle(0, 0, 0, '0, 1);

        // Generator output and looped-back checker.
        cycle(1, 0, 0, '0, 0);
        cycle(1, 0, 0, '0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(1, 0, 0, '0, 1);
            check("t3_gen", 32'(s_out_data), 32'(k));
        end
        for (int k = 0; k < 5; k++) cycle(1, 0, 1, WIDTH'(k), 0);
        cycle(1, 0, 1, WIDTH'(5), 0);
        cycle(1, 0, 0, '0, 0);
        check("t3_err", 32'(s_err), 32'd0);

        // Mismatch with resync: 0,1,7,8.
        cycle(1, 1, 0, '0, 0);
        cycle(1, 0, 1, WIDTH'(0), 0);
        cycle(1, 0, 1, WIDTH'(1), 0);
        cycle(1, 0, 1, WIDTH'(7), 0);
        cycle(1, 0, 1, WIDTH'(8), 0);
        cycle(1, 0, 0, '0, 0);
        check("t4_err", 32'(s_err), 32'd1);

        // Mode switch with data buffered.
        cycle(0, 0, 0, '0, 0);
        cycle(0, 0, 0, '0, 0);
        cycle(0, 1, 0, '0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, WIDTH'(16'hA0 + i), 0);
        cycle(1, 0, 0, '0, 0);
        cycle(1, 0, 0, '0, 0);
        check("t5_flush_ready", 32'(s_in_ready), 32'd0);
        check("t5_flush_valid", 32'(s_out_valid), 32'd0);
        check("t5_flush_level", 32'(s_level), 32'd0);
        cycle(1, 0, 0, '0, 0);
        check("t5_gen_valid", 32'(s_out_valid), 32'd1);
        check("t5_gen_data", 32'(s_out_data), 32'd0);
        check("t5_rx", 32'(s_rx), 32'd3);

        // logic_rst clears statistics; then saturate err_cnt.
        cycle(1, 0, 1, WIDTH'(16'h55), 1);
        cycle(1, 1, 0, '0, 0);
        cycle(1, 0, 0, '0, 0);
        check("t6_rx", 32'(s_rx), 32'd0);
        check("t6_tx", 32'(s_tx), 32'd0);
        check("t6_err", 32'(s_err), 32'd0);
        check("t6_level", 32'(s_level), 32'd0);
        repeat (260) cycle(1, 0, 1, m_exp + WIDTH'(3), 0);
        cycle(1, 0, 0, '0, 0);
        check("t6_err_sat", 32'(s_err), 32'hFF);
        cycle(1, 0, 1, m_exp + WIDTH'(3), 0);
        cycle(1, 0, 0, '0, 0);
        check("t6_err_hold", 32'(s_err), 32'hFF);

        // Asynchronous reset in the middle of loopback traffic.
        cycle(0, 0, 0, '0, 0);
        cycle(0, 0, 0, '0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, WIDTH'($urandom), bit'(i % 2));
        do_reset();
        repeat (2) cycle(0, 0, 0, '0, 0);

        // Random traffic across both modes, with occasional mode flips and logic_rst.
        for (int n = 0; n < 3000; n++) begin
            md = mode;
            if ($urandom_range(0, 63) == 0) md = !md;
            lr   = ($urandom_range(0, 99) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            if (m_mode && $urandom_range(0, 9) != 0) id = m_exp;
            else id = WIDTH'($urandom);
            cycle(md, lr, iv, id, ordy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
